// File: rtl/gbsha_fir_pkg.sv
// Shared constants and types for the gbsha FIR and its decimator.
package gbsha_fir_pkg;

   localparam int BW_IN      = 8;
   localparam int BW_OUT     = 8;
   localparam int LOG2_R_DEF = 2;

   typedef logic signed [BW_IN-1:0] sample_t;

   // phase/counter width: at least one bit even when the window is a single sample
   function automatic int phase_w(input int log2_r);
      return (log2_r > 0) ? log2_r : 1;
   endfunction

endpackage

// File: rtl/gbsha_fir_decim_if.sv
// Sample-in / average-out bus of the gbsha decimator.
interface gbsha_fir_decim_if
   import gbsha_fir_pkg::*;
#(
   parameter int BW_in  = BW_IN,
   parameter int BW_out = BW_OUT,
   parameter int LOG2_R = LOG2_R_DEF
);
   localparam int PW = phase_w(LOG2_R);

   logic                     en;
   logic signed [BW_in-1:0]  y_in;
   logic                     peak_clr;
   logic signed [BW_out-1:0] d_out;
   logic                     d_valid;
   logic [BW_out-2:0]        peak;
   logic [PW-1:0]            phase;

   modport master (
      output en, y_in, peak_clr,
      input  d_out, d_valid, peak, phase
   );

   modport slave (
      input  en, y_in, peak_clr,
      output d_out, d_valid, peak, phase
   );
endinterface

// File: rtl/gbsha_round_sat.sv
// Round-half-up arithmetic right shift by SH, then saturate to W_OUT signed bits.
module gbsha_round_sat #(
   parameter int W_IN  = 10,
   parameter int SH    = 2,
   parameter int W_OUT = 8
) (
   input  logic signed [W_IN-1:0]  a_i,
   output logic signed [W_OUT-1:0] y_o
);
   localparam int WX    = W_IN + 1;
   localparam int RND_I = (SH > 0) ? (1 << ((SH > 0) ? SH - 1 : 0)) : 0;
   localparam logic signed [WX-1:0] RND = WX'(RND_I);

   logic signed [WX-1:0] ext;
   logic signed [WX-1:0] r;

   // one extra bit so the rounding add cannot wrap
   assign ext = WX'(a_i) + RND;
   assign r   = ext >>> SH;

   generate
      if (W_OUT >= WX) begin : g_wide
         assign y_o = W_OUT'(r);
      end else begin : g_sat
         logic [WX-W_OUT:0] hi;
         assign hi = r[WX-1:W_OUT-1];
         always_comb begin
            if (!r[WX-1] && (|hi))
               y_o = {1'b0, {(W_OUT-1){1'b1}}};
            else if (r[WX-1] && !(&hi))
               y_o = {1'b1, {(W_OUT-1){1'b0}}};
            else
               y_o = r[W_OUT-1:0];
         end
      end
   endgenerate
endmodule

// File: rtl/gbsha_fir_decim.sv
// Integrate-and-dump decimator: averages 2^LOG2_R enabled samples, tracks peak |avg|.
module gbsha_fir_decim
   import gbsha_fir_pkg::*;
#(
   parameter int BW_in  = BW_IN,
   parameter int BW_out = BW_OUT,
   parameter int LOG2_R = LOG2_R_DEF
) (
   input  logic              clk,
   input  logic              rst,
   gbsha_fir_decim_if.slave  bus
);
   localparam int AW = BW_in + LOG2_R;
   localparam int PW = phase_w(LOG2_R);
   localparam logic [PW-1:0] LAST = PW'((1 << LOG2_R) - 1);

   logic signed [AW-1:0]     acc_q, acc_d, sum;
   logic [PW-1:0]            cnt_q, cnt_d;
   logic signed [BW_out-1:0] dout_q, dout_d, avg;
   logic                     vld_q, vld_d;
   logic [BW_out-2:0]        peak_q, peak_d, mag;
   logic [BW_out-1:0]        mag_full;
   logic                     dump;

   assign sum  = acc_q + AW'($signed(bus.y_in));
   assign dump = bus.en && (cnt_q == LAST);

   gbsha_round_sat #(
      .W_IN  (AW),
      .SH    (LOG2_R),
      .W_OUT (BW_out)
   ) u_round_sat (
      .a_i (sum),
      .y_o (avg)
   );

   // |most-negative| does not fit in BW_out-1 bits, so it clips to the max
   assign mag_full = avg[BW_out-1] ? BW_out'(-avg) : avg;
   assign mag      = mag_full[BW_out-1] ? '1 : mag_full[BW_out-2:0];

   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      dout_d = dout_q;
      vld_d  = 1'b0;
      peak_d = bus.peak_clr ? '0 : peak_q;
      if (bus.en) begin
         if (dump) begin
            acc_d  = '0;
            cnt_d  = '0;
            dout_d = avg;
            vld_d  = 1'b1;
            peak_d = (bus.peak_clr || (mag > peak_q)) ? mag : peak_q;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
         vld_q  <= 1'b0;
         peak_q <= '0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         vld_q  <= vld_d;
         peak_q <= peak_d;
      end
   end

   assign bus.d_out   = dout_q;
   assign bus.d_valid = vld_q;
   assign bus.peak    = peak_q;
   assign bus.phase   = cnt_q;
endmodule

// File: tb/tb_gbsha_fir_decim.sv
// Directed bench for gbsha_fir_decim at default parameters (R=4).
module tb_gbsha_fir_decim;
   import gbsha_fir_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   nvld;

   always #5 clk = ~clk;

   gbsha_fir_decim_if #(.BW_in(BW_IN), .BW_out(BW_OUT), .LOG2_R(LOG2_R_DEF)) bus ();

   gbsha_fir_decim #(.BW_in(BW_IN), .BW_out(BW_OUT), .LOG2_R(LOG2_R_DEF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // drive at the falling edge, let one rising edge happen, sample 1ns later
   task automatic stp(input logic r, input logic e, input int y, input logic c);
      @(negedge clk);
      rst          = r;
      bus.en       = e;
      bus.y_in     = sample_t'(y);
      bus.peak_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int dout, input int vld,
                          input int pk, input int ph);
      chk({tag, ".d_out"},   $signed(bus.d_out), dout);
      chk({tag, ".d_valid"}, {31'd0, bus.d_valid}, vld);
      chk({tag, ".peak"},    {25'd0, bus.peak}, pk);
      chk({tag, ".phase"},   {30'd0, bus.phase}, ph);
   endtask

   initial begin
      bus.en = 1'b1; bus.y_in = '0; bus.peak_clr = 1'b0;

      // 1. reset holds everything at zero despite en=1
      for (int i = 0; i < 3; i++) stp(1'b0, 1'b1, 8'h55, 1'b0);
      chk_out("reset", 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         stp(1'b1, 1'b1, 8'h55, 1'b0);
         chk_out($sformatf("first_win%0d", i), 0, 0, 0, i);
      end
      stp(1'b1, 1'b1, 8'h55, 1'b0);
      chk_out("first_dump", 85, 1, 85, 0);

      // 2. constant 10, two windows
      nvld = 0;
      for (int i = 1; i <= 8; i++) begin
         stp(1'b1, 1'b1, 10, 1'b0);
         if (bus.d_valid === 1'b1) nvld++;
         chk($sformatf("const.phase%0d", i), {30'd0, bus.phase}, i % 4);
         chk($sformatf("const.vld%0d", i), {31'd0, bus.d_valid}, (i % 4 == 0) ? 1 : 0);
         if (i % 4 == 0) chk($sformatf("const.dout%0d", i), $signed(bus.d_out), 10);
      end
      chk("const.nvld", nvld, 2);

      stp(1'b1, 1'b0, 0, 1'b1);
      chk_out("clr_idle", 10, 0, 0, 0);

      // 3. rounding, positive and negative
      for (int i = 1; i <= 4; i++) stp(1'b1, 1'b1, i, 1'b0);
      chk_out("round_pos", 3, 1, 3, 0);
      for (int i = 1; i <= 4; i++) stp(1'b1, 1'b1, -i, 1'b0);
      chk_out("round_neg", -2, 1, 3, 0);

      // 4. en gating: x=100 with en=0 must be ignored
      stp(1'b1, 1'b1, 5, 1'b0);   chk_out("gate1", -2, 0, 3, 1);
      stp(1'b1, 1'b0, 100, 1'b0); chk_out("gate2", -2, 0, 3, 1);
      stp(1'b1, 1'b1, 6, 1'b0);   chk_out("gate3", -2, 0, 3, 2);
      stp(1'b1, 1'b0, 100, 1'b0); chk_out("gate4", -2, 0, 3, 2);
      stp(1'b1, 1'b1, 7, 1'b0);   chk_out("gate5", -2, 0, 3, 3);
      stp(1'b1, 1'b0, 100, 1'b0); chk_out("gate6", -2, 0, 3, 3);
      stp(1'b1, 1'b1, 8, 1'b0);   chk_out("gate7", 7, 1, 7, 0);

      // 5. extremes and peak clear
      for (int i = 0; i < 4; i++) stp(1'b1, 1'b1, -128, 1'b0);
      chk_out("min", -128, 1, 127, 0);
      for (int i = 0; i < 4; i++) stp(1'b1, 1'b1, 127, 1'b0);
      chk_out("max", 127, 1, 127, 0);
      stp(1'b1, 1'b0, 0, 1'b1);
      chk_out("clr_alone", 127, 0, 0, 0);
      for (int i = 0; i < 3; i++) stp(1'b1, 1'b1, 3, 1'b0);
      stp(1'b1, 1'b1, 3, 1'b1);
      chk_out("clr_dump", 3, 1, 3, 0);

      // 6. reset mid-window discards the partial sum
      stp(1'b1, 1'b1, 50, 1'b0);
      stp(1'b1, 1'b1, 50, 1'b0);
      chk_out("pre_rst", 3, 0, 3, 2);
      stp(1'b0, 1'b1, 50, 1'b0);
      chk_out("mid_rst", 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         stp(1'b1, 1'b1, 8, 1'b0);
         chk_out($sformatf("post_rst%0d", i), 0, 0, 0, i);
      end
      stp(1'b1, 1'b1, 8, 1'b0);
      chk_out("post_rst_dump", 8, 1, 8, 0);
      stp(1'b1, 1'b0, 0, 1'b0);
      chk_out("strobe_drop", 8, 0, 8, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gbsha_fir_decim.md
Name: gbsha_fir_decim

Overview:
- Downstream stage of the gbsha FIR.
- Consumes the FIR's two's-complement y samples and integrates R = 2^LOG2_R consecutive enabled samples.
- Dumps a rounded, saturated average with a one-cycle valid strobe, which reduces the output rate for the 8-pin TinyTapeout io_out.
- Tracks a peak-magnitude register over dumped averages, clearable by the host.

Parameters:
- BW_in, 8, width of the incoming FIR output sample, signed two's complement.
- BW_out, 8, width of the decimated output, signed.
- LOG2_R, 2, log2 of the decimation ratio; legal range 0..4.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset); sampled only at the clk rising edge.
- en  input  1  sample-valid qualifier for y_in; tie high for the free-running FIR.
- y_in  input  BW_in  FIR output sample, signed.
- peak_clr  input  1  synchronous clear of the peak register.
- d_out  output  BW_out  latest decimated average, signed, registered.
- d_valid  output  1  one-cycle strobe; high in the cycle d_out takes a new value.
- peak  output  BW_out-1  max |d_out| since reset or the last clear, unsigned, registered.
- phase  output  max(LOG2_R,1)  current sample index within the window (0..R-1).

Behaviour:
- Reset (rst=0 at an edge):
  - acc=0, cnt=0, d_out=0, d_valid=0, peak=0, phase=0.
  - Reset overrides en and peak_clr.
  - Reset mid-window discards the partial sum; the next window starts fresh.
- Accumulator acc is signed, width BW_in+LOG2_R; it cannot overflow.
- Edge with en=1 and cnt<R-1: acc <= acc + sext(y_in); cnt <= cnt+1; d_valid <= 0.
- Edge with en=1 and cnt==R-1 (dump):
  - sum = acc + sext(y_in).
  - r = (sum + 2^(LOG2_R-1)) >>> LOG2_R (round half up), computed at width BW_in+LOG2_R+1.
  - d_out <= sat(r) to the signed BW_out range [-2^(BW_out-1), 2^(BW_out-1)-1].
  - d_valid <= 1; acc <= 0; cnt <= 0.
- Edge with en=0: acc, cnt and d_out hold; d_valid <= 0.
- Latency: d_out/d_valid are visible in the cycle after the edge that captured the R-th enabled sample.
- d_valid is never high two cycles in a row unless LOG2_R=0.
- LOG2_R=0: no rounding term, cnt is stuck at 0, every enabled sample dumps; d_out = sat(y_in) registered, d_valid = en delayed by one cycle.
- Peak:
  - On a dump edge: m = |sat(r)|, with |-2^(BW_out-1)| saturated to 2^(BW_out-1)-1.
  - peak <= max(peak, m); with peak_clr=1 in the same edge, peak <= m.
  - peak_clr=1 without a dump: peak <= 0.
- phase = cnt.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package gbsha_fir_pkg holds:
  - BW_in/BW_out sample-width constants shared with the FIR and the top.
  - The signed sample typedef.
  - The default decimation exponent.
- One combinational sub-module, gbsha_round_sat: signed input of width W_IN, shift SH, output width W_OUT. It performs the round-half-up arithmetic shift and saturation, and is reused by the FIR output stage.
- The counter, accumulator and peak logic stay in gbsha_fir_decim.

Test Plan (defaults, R=4):
1. Reset: rst=0 for 3 edges with y_in=0x55, en=1 → d_out=0, d_valid=0, peak=0, phase=0. Release; first d_valid appears exactly one cycle after the 4th enabled sample.
2. Constant y_in=10, en=1, 8 samples → d_valid high exactly twice, 4 cycles apart, d_out=10 both times, phase cycles 0,1,2,3,0,…
3. Rounding:
   - Samples 1,2,3,4 (sum 10) → d_out=3.
   - Samples −1,−2,−3,−4 (sum −10) → d_out=−2 (0xFE); peak=3.
4. en gating: samples 5,x,6,x,7,x,8 with en=1,0,1,0,1,0,1 (x=100) → one d_valid, d_out=7 (26+2>>2); the x values are ignored; phase holds while en=0.
5. Extremes:
   - −128 ×4 → d_out=−128 (0x80), peak=127.
   - Then 127 ×4 → d_out=127, peak=127.
   - peak_clr pulse alone → peak=0.
   - peak_clr coincident with a dump of 3 → peak=3.
6. Reset mid-window: 2 samples of 50, rst=0 for one edge, then 4 samples of 8 → no d_valid before the 4th post-reset sample; d_out=8.
